// File: rtl/drum_pkg.sv
// Shared widths for the drum multiplier tile and its dot-product accumulator.
// Width helpers keep the accumulator wide enough that no sum can overflow.
package drum_pkg;

    localparam int DRUM_N        = 8;
    localparam int DRUM_M        = 8;
    localparam int PROD_W_DEF    = DRUM_N + DRUM_M;
    localparam int OUT_W_DEF     = 16;
    localparam int MAX_TERMS_DEF = 8;

    function automatic int acc_w(input int prod_w, input int max_terms);
        return prod_w + $clog2(max_terms);
    endfunction

    function automatic int cnt_w(input int max_terms);
        return $clog2(max_terms + 1);
    endfunction

endpackage

// File: rtl/drum_narrow.sv
// Narrows the wide accumulator sum to the result width and flags lost range.
// DRUM_DOT_ACC_SAT_EN selects saturation; otherwise the result wraps.
module drum_narrow
    import drum_pkg::*;
#(
    parameter int ACC_W = 19,
    parameter int OUT_W = 16
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] sum_o,
    output logic                    ovf_o
);

    generate
        if (ACC_W > OUT_W) begin : g_narrow
            logic [ACC_W-OUT_W:0] hi;

            // In range exactly when the top bits are all copies of the sign.
            assign hi    = acc_i[ACC_W-1:OUT_W-1];
            assign ovf_o = !((&hi) || !(|hi));

`ifdef DRUM_DOT_ACC_SAT_EN
            localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
            localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

            assign sum_o = !ovf_o ? acc_i[OUT_W-1:0]
                         : (acc_i[ACC_W-1] ? MINV : MAXV);
`else
            assign sum_o = acc_i[OUT_W-1:0];
`endif
        end else begin : g_widen
            assign sum_o = OUT_W'(acc_i);
            assign ovf_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/drum_dot_acc.sv
// Dot-product accumulator behind the drum multiplier; one result per vector.
// Build option DRUM_DOT_ACC_SAT_EN makes the narrowed result saturate.
module drum_dot_acc
    import drum_pkg::*;
#(
    parameter  int PROD_W    = PROD_W_DEF,
    parameter  int MAX_TERMS = MAX_TERMS_DEF,
    parameter  int OUT_W     = OUT_W_DEF,
    localparam int CNT_W     = cnt_w(MAX_TERMS),
    localparam int ACC_W     = acc_w(PROD_W, MAX_TERMS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_prod,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_sum,
    output logic        [CNT_W-1:0]  out_count,
    output logic                     out_ovf
);

    logic signed [ACC_W-1:0] acc_q, acc_d, nxt;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic signed [OUT_W-1:0] sum_q, sum_d, nar_sum;
    logic        [CNT_W-1:0] count_q, count_d;
    logic                    ovf_q, ovf_d, nar_ovf;
    logic                    accept, close;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign nxt      = acc_q + ACC_W'(in_prod);
    assign close    = in_last || (cnt_q == CNT_W'(MAX_TERMS - 1));

    drum_narrow #(
        .ACC_W(ACC_W),
        .OUT_W(OUT_W)
    ) u_narrow (
        .acc_i(nxt),
        .sum_o(nar_sum),
        .ovf_o(nar_ovf)
    );

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        valid_d = valid_q && !out_ready;
        sum_d   = sum_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (accept) begin
            if (close) begin
                acc_d   = '0;
                cnt_d   = '0;
                valid_d = 1'b1;
                sum_d   = nar_sum;
                count_d = cnt_q + CNT_W'(1);
                ovf_d   = nar_ovf;
            end else begin
                acc_d = nxt;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_drum_dot_acc.sv
// Bench for drum_dot_acc: directed scenarios plus a randomized scoreboard run.
// Expected results come from integer sums narrowed by a plain arithmetic model.
module tb_drum_dot_acc;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_prod = '0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] out_sum;
    logic        [3:0]  out_count;
    logic               out_ovf;
    logic        [21:0] obs;

    int passed = 0;
    int total  = 0;

    drum_dot_acc dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_prod(in_prod),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_count(out_count),
        .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    assign obs = {out_valid, out_sum, out_count, out_ovf};

    // Reference: exact integer sum, then clamp or wrap to 16 bits.
    function automatic logic [21:0] model_result(input bit v, input int s, input int c);
        logic [15:0] r;
        logic        o;
        int          sv;
        logic [3:0]  cv;
        sv = s;
        cv = c[3:0];
        o  = (s > 32767) || (s < -32768);
`ifdef DRUM_DOT_ACC_SAT_EN
        if (s > 32767) r = 16'h7fff;
        else if (s < -32768) r = 16'h8000;
        else r = sv[15:0];
`else
        r = sv[15:0];
`endif
        return {v, r, cv, o};
    endfunction

    task automatic drive(input bit v, input int p, input bit l);
        in_valid = v;
        in_prod  = p[15:0];
        in_last  = l;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            drive(1, p, k == n - 1);
            tick();
        end
        drive(0, 0, 0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        out_ready = 1'b0;
        drive(0, 0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        total++;
        if (obs !== 22'h0) $display("FAIL reset_out: got %h want %h", obs, 22'h0);
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        drive(1, 100, 0); tick();
        drive(1, -50, 0); tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL basic_early: got %b want 0", out_valid);
        else passed++;
        drive(1, 25, 1); tick();
        drive(0, 0, 0);
        total++;
        if (obs !== model_result(1, 75, 3))
            $display("FAIL basic_result: got %h want %h", obs, model_result(1, 75, 3));
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL basic_drop: got %b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_autoclose;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1000, 0);
            tick();
            if (i == 6) begin
                total++;
                if (out_valid !== 1'b0) $display("FAIL auto_early: got %b want 0", out_valid);
                else passed++;
            end
        end
        total++;
        if (obs !== model_result(1, 8000, 8))
            $display("FAIL auto_result: got %h want %h", obs, model_result(1, 8000, 8));
        else passed++;
        drive(1, 1000, 1); tick();
        drive(0, 0, 0);
        total++;
        if (obs !== model_result(1, 1000, 1))
            $display("FAIL auto_next: got %h want %h", obs, model_result(1, 1000, 1));
        else passed++;
        tick();
    endtask

    task automatic test_overflow;
        int vals[8];
        int ns[8];
        vals = '{30000, -30000, 16384, -16384, 10923, 8191, 32767, -32768};
        ns   = '{4, 4, 2, 2, 3, 4, 1, 8};
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            send_vec(vals[c], ns[c]);
            total++;
            if (obs !== model_result(1, vals[c] * ns[c], ns[c]))
                $display("FAIL ovf_case%0d: got %h want %h", c, obs,
                         model_result(1, vals[c] * ns[c], ns[c]));
            else passed++;
            tick();
            total++;
            if (out_valid !== 1'b0) $display("FAIL ovf_single%0d: got %b want 0", c, out_valid);
            else passed++;
        end
    endtask

    task automatic test_backpressure;
        logic [21:0] held;
        out_ready = 1'b1;
        drive(1, 5, 1); tick();
        held = model_result(1, 5, 1);
        out_ready = 1'b0;
        drive(1, 7, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0) $display("FAIL bp_ready%0d: got %b want 0", i, in_ready);
            else passed++;
            total++;
            if (obs !== held) $display("FAIL bp_hold%0d: got %h want %h", i, obs, held);
            else passed++;
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL bp_release: got %b want 1", in_ready);
        else passed++;
        tick();
        drive(0, 0, 0);
        total++;
        if (obs !== model_result(1, 7, 1))
            $display("FAIL bp_new: got %h want %h", obs, model_result(1, 7, 1));
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL bp_drop: got %b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int p;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            p = int'($signed(16'($urandom)));
            drive(1, p, 1);
            tick();
            total++;
            if (obs !== model_result(1, p, 1))
                $display("FAIL b2b_%0d: got %h want %h", i, obs, model_result(1, p, 1));
            else passed++;
        end
        drive(0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        drive(1, 500, 0); tick();
        drive(1, 500, 0); tick();
        drive(0, 0, 0);
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        total++;
        if (obs !== 22'h0) $display("FAIL rst_mid_vec: got %h want %h", obs, 22'h0);
        else passed++;
        drive(1, 7, 1); tick();
        drive(0, 0, 0);
        total++;
        if (obs !== model_result(1, 7, 1))
            $display("FAIL rst_mid_next: got %h want %h", obs, model_result(1, 7, 1));
        else passed++;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL rst_mid_out: got %b want 0", out_valid);
        else passed++;
        out_ready = 1'b1;
    endtask

    task automatic test_random;
        logic [21:0] expq[$];
        logic [21:0] e;
        int          psum;
        int          pcnt;
        int          p;
        psum = 0;
        pcnt = 0;
        drive(0, 0, 0);
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 3) == 0) p = int'($signed(16'($urandom)));
            else p = int'($urandom_range(0, 400)) - 200;
            drive($urandom_range(0, 3) != 0, p, $urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            total++;
            if (in_ready !== (!out_valid || out_ready))
                $display("FAIL rnd_ready@%0d: got %b want %b", cyc, in_ready,
                         !out_valid || out_ready);
            else passed++;
            if (out_valid && out_ready) begin
                total++;
                if (expq.size() == 0) begin
                    $display("FAIL rnd_extra@%0d: got %h want none", cyc, obs);
                end else begin
                    e = expq.pop_front();
                    if (obs !== e) $display("FAIL rnd_res@%0d: got %h want %h", cyc, obs, e);
                    else passed++;
                end
            end
            if (in_valid && in_ready) begin
                psum += p;
                pcnt++;
                if (in_last || pcnt == 8) begin
                    expq.push_back(model_result(1, psum, pcnt));
                    psum = 0;
                    pcnt = 0;
                end
            end
            tick();
        end
        drive(0, 0, 0);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) begin
                total++;
                if (expq.size() == 0) begin
                    $display("FAIL rnd_drain_extra: got %h want none", obs);
                end else begin
                    e = expq.pop_front();
                    if (obs !== e) $display("FAIL rnd_drain: got %h want %h", obs, e);
                    else passed++;
                end
            end
            tick();
        end
        total++;
        if (expq.size() != 0 || out_valid !== 1'b0)
            $display("FAIL rnd_left: got %0d pending valid=%b want 0 pending valid=0",
                     expq.size(), out_valid);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_autoclose();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
